// File: rtl/rv_decode_queue.sv
// rtl/rv_decode_queue.sv - RV32I instruction decoder feeding a DEPTH-entry decoded-item FIFO
module rv_decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 out_code,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [XLEN-1:0]            out_imm,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           illegal_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [5:0] NO_INST = 6'd37;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    assign imm_i  = XLEN'($signed(in_inst[31:20]));
    assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
    assign imm_sh = XLEN'(in_inst[24:20]);

    logic [5:0]      d_code;
    logic [4:0]      d_rs1, d_rs2, d_rd;
    logic [XLEN-1:0] d_imm;

    // Codes: I-ALU 0-8, loads 9-13, JALR 14, R-type 15-24, LUI 25, AUIPC 26,
    // JAL 27, stores 28-30, branches 31-36.
    always_comb begin
        d_code = NO_INST;
        d_rs1  = in_inst[19:15];
        d_rs2  = '0;
        d_rd   = in_inst[11:7];
        d_imm  = '0;
        unique case (opc)
            7'b0110011: begin
                d_rs2 = in_inst[24:20];
                if (f7 == 7'b0000000) begin
                    unique case (f3)
                        3'd0: d_code = 6'd15;
                        3'd1: d_code = 6'd17;
                        3'd2: d_code = 6'd18;
                        3'd3: d_code = 6'd19;
                        3'd4: d_code = 6'd20;
                        3'd5: d_code = 6'd21;
                        3'd6: d_code = 6'd23;
                        3'd7: d_code = 6'd24;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'd0) d_code = 6'd16;
                    else if (f3 == 3'd5) d_code = 6'd22;
                end
            end
            7'b0010011: begin
                d_imm = imm_i;
                unique case (f3)
                    3'd0: d_code = 6'd0;
                    3'd2: d_code = 6'd1;
                    3'd3: d_code = 6'd2;
                    3'd4: d_code = 6'd3;
                    3'd6: d_code = 6'd4;
                    3'd7: d_code = 6'd5;
                    3'd1: begin
                        d_imm = imm_sh;
                        if (f7 == 7'b0000000) d_code = 6'd6;
                    end
                    3'd5: begin
                        d_imm = imm_sh;
                        if (f7 == 7'b0000000) d_code = 6'd7;
                        else if (f7 == 7'b0100000) d_code = 6'd8;
                    end
                endcase
            end
            7'b0000011: begin
                d_imm = imm_i;
                unique case (f3)
                    3'd0: d_code = 6'd9;
                    3'd1: d_code = 6'd10;
                    3'd2: d_code = 6'd11;
                    3'd4: d_code = 6'd12;
                    3'd5: d_code = 6'd13;
                    default: d_code = NO_INST;
                endcase
            end
            7'b1100111: begin
                d_imm = imm_i;
                if (f3 == 3'd0) d_code = 6'd14;
            end
            7'b0100011: begin
                d_rs2 = in_inst[24:20];
                d_rd  = '0;
                d_imm = imm_s;
                unique case (f3)
                    3'd0: d_code = 6'd28;
                    3'd1: d_code = 6'd29;
                    3'd2: d_code = 6'd30;
                    default: d_code = NO_INST;
                endcase
            end
            7'b1100011: begin
                d_rs2 = in_inst[24:20];
                d_rd  = '0;
                d_imm = imm_b;
                unique case (f3)
                    3'd0: d_code = 6'd31;
                    3'd1: d_code = 6'd32;
                    3'd4: d_code = 6'd33;
                    3'd5: d_code = 6'd34;
                    3'd6: d_code = 6'd35;
                    3'd7: d_code = 6'd36;
                    default: d_code = NO_INST;
                endcase
            end
            7'b0110111: begin d_code = 6'd25; d_rs1 = '0; d_imm = imm_u; end
            7'b0010111: begin d_code = 6'd26; d_rs1 = '0; d_imm = imm_u; end
            7'b1101111: begin d_code = 6'd27; d_rs1 = '0; d_imm = imm_j; end
            default: d_code = NO_INST;
        endcase
        // Illegal items carry no operand fields at all.
        if (d_code == NO_INST) begin
            d_rs1 = '0;
            d_rs2 = '0;
            d_rd  = '0;
            d_imm = '0;
        end
    end

    logic [5:0]      mem_code [DEPTH];
    logic [4:0]      mem_rs1  [DEPTH];
    logic [4:0]      mem_rs2  [DEPTH];
    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_imm  [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_code[wr_ptr] <= d_code;
            mem_rs1[wr_ptr]  <= d_rs1;
            mem_rs2[wr_ptr]  <= d_rs2;
            mem_rd[wr_ptr]   <= d_rd;
            mem_imm[wr_ptr]  <= d_imm;
            mem_pc[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            illegal_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (push && d_code == NO_INST && illegal_cnt != '1)
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    // Storage is not reset, so every data output is gated to zero when empty.
    assign out_code    = out_valid ? mem_code[rd_ptr] : '0;
    assign out_rs1     = out_valid ? mem_rs1[rd_ptr]  : '0;
    assign out_rs2     = out_valid ? mem_rs2[rd_ptr]  : '0;
    assign out_rd      = out_valid ? mem_rd[rd_ptr]   : '0;
    assign out_imm     = out_valid ? mem_imm[rd_ptr]  : '0;
    assign out_pc      = out_valid ? mem_pc[rd_ptr]   : '0;
    assign out_illegal = out_valid && (mem_code[rd_ptr] == NO_INST);
endmodule

// File: tb/tb_rv_decode_queue.sv
// tb/tb_rv_decode_queue.sv - table-driven and sequence checks for rv_decode_queue
module tb_rv_decode_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_pc, out_imm, out_pc;
    logic [5:0]  out_code;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  count;
    logic [2:0]  illegal_cnt;

    int n_total = 0;
    int n_pass  = 0;

    rv_decode_queue #(.XLEN(32), .DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal),
        .count(count), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  code;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] pack(input logic v, input logic [5:0] c, input logic [4:0] r1,
                                         input logic [4:0] r2, input logic [4:0] rd,
                                         input logic [31:0] im, input logic il);
        return 64'({v, c, r1, r2, rd, im, il});
    endfunction

    function automatic logic [63:0] head();
        return pack(out_valid, out_code, out_rs1, out_rs2, out_rd, out_imm, out_illegal);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{32'hFFF10093, 6'd0,  5'd2, 5'd0, 5'd1,  32'hFFFFFFFF};
        tbl[1]  = '{32'h405201B3, 6'd16, 5'd4, 5'd5, 5'd3,  32'h00000000};
        tbl[2]  = '{32'h123452B7, 6'd25, 5'd0, 5'd0, 5'd5,  32'h12345000};
        tbl[3]  = '{32'hFE208EE3, 6'd31, 5'd1, 5'd2, 5'd0,  32'hFFFFFFFC};
        tbl[4]  = '{32'h00000000, 6'd37, 5'd0, 5'd0, 5'd0,  32'h00000000};
        tbl[5]  = '{32'h00512423, 6'd30, 5'd2, 5'd5, 5'd0,  32'h00000008};
        tbl[6]  = '{32'h40525193, 6'd8,  5'd4, 5'd0, 5'd3,  32'h00000005};
        tbl[7]  = '{32'hFFC3A303, 6'd11, 5'd7, 5'd0, 5'd6,  32'hFFFFFFFC};
        tbl[8]  = '{32'h010000EF, 6'd27, 5'd0, 5'd0, 5'd1,  32'h00000010};
        tbl[9]  = '{32'hFFFFF517, 6'd26, 5'd0, 5'd0, 5'd10, 32'hFFFFF000};
        tbl[10] = '{32'h02208033, 6'd37, 5'd0, 5'd0, 5'd0,  32'h00000000};
        tbl[11] = '{32'h40109093, 6'd37, 5'd0, 5'd0, 5'd0,  32'h00000000};
        tbl[12] = '{32'h0020F463, 6'd36, 5'd1, 5'd2, 5'd0,  32'h00000008};

        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {59'(count), illegal_cnt, out_valid, in_ready},
            {59'd0, 3'd0, 1'b0, 1'b1});
        chk("reset_head", head(), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; in_inst = tbl[i].inst; in_pc = 32'h1000 + 32'(i * 4);
            step();
            in_valid = 1'b0;
            chk($sformatf("decode_%0d", i), head(),
                pack(1'b1, tbl[i].code, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm,
                     tbl[i].code == 6'd37));
            chk($sformatf("pc_%0d", i), 64'(out_pc), 64'(32'h1000 + 32'(i * 4)));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk("illegal_cnt_after_table", 64'(illegal_cnt), 64'd3);

        // Back-to-back SUB then LUI with the consumer always ready; count=1 push+pop.
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h405201B3;
        step();
        chk("b2b_sub", head(), pack(1'b1, 6'd16, 5'd4, 5'd5, 5'd3, 32'd0, 1'b0));
        in_inst = 32'h123452B7;
        step();
        chk("b2b_lui", head(), pack(1'b1, 6'd25, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b0));
        chk("b2b_count", 64'(count), 64'd1);
        in_valid = 1'b0;
        step();
        chk("b2b_drained", {62'd0, out_valid, in_ready}, 64'd1);

        // Fill with out_ready low, offer a 5th word, then free one slot.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_inst = (32'(k) << 20) | 32'h00000093;
            step();
        end
        chk("full_state", {61'(count), in_ready}, {61'd4, 1'b0});
        in_inst = (32'd5 << 20) | 32'h00000093;
        step();
        chk("full_hold", {59'(count), out_imm[3:0], in_ready}, {59'd4, 4'd1, 1'b0});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("one_pop", {61'(count), in_ready}, {61'd3, 1'b1});
        step();
        in_valid = 1'b0;
        chk("fifth_in", 64'(count), 64'd4);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("order_%0d", k), {32'(out_code), out_imm}, {32'd0, 32'(k)});
            step();
        end
        chk("order_empty", 64'(out_valid), 64'd0);

        // Five illegal words streamed: counter saturates at 7.
        in_valid = 1'b1; in_inst = 32'h00001067;
        repeat (5) step();
        in_valid = 1'b0;
        chk("illegal_sat", 64'(illegal_cnt), 64'd7);
        chk("illegal_head", head(), pack(1'b1, 6'd37, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));
        step();

        // Asynchronous reset with three items queued.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF10093;
        repeat (3) step();
        in_valid = 1'b0;
        chk("pre_reset_count", 64'(count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {56'(count), illegal_cnt, out_valid, in_ready, out_code[0], out_illegal},
            {56'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_inst = 32'h0020F463;
        step();
        in_valid = 1'b0;
        chk("post_reset_push", head(), pack(1'b1, 6'd36, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
